set_sched: RTL

SET_SCHED -- requirements
Module: set_sched

---
 rtl/set_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/set_sched.sv
// Two-port round-robin job scheduler for the circle-count engine: one job in flight, watchdog on the engine response.
// Accept to res_valid is 3 cycles plus engine latency (1 cycle for illegal mode); result held until res_ready.
module set_sched #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [23:0] req0_central,
   input  logic [23:0] req1_central,
   input  logic [11:0] req0_radius,
   input  logic [11:0] req1_radius,
   input  logic [1:0]  req0_mode,
   input  logic [1:0]  req1_mode,
   output logic        eng_en,
   output logic [23:0] eng_central,
   output logic [11:0] eng_radius,
   output logic [1:0]  eng_mode,
   input  logic        eng_valid,
   input  logic [7:0]  eng_candidate,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        res_id,
   output logic [7:0]  res_candidate,
   output logic        res_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [23:0] central;
      logic [11:0] radius;
      logic [1:0]  mode;
   } job_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   job_t       job_q, job_d;
   logic       ptr_q, ptr_d;
   logic       id_q, id_d;
   logic       eng_en_q, eng_en_d;
   logic       res_valid_q, res_valid_d;
   logic [7:0] cand_q, cand_d;
   logic       err_q, err_d;
   logic [7:0] wd_q, wd_d;
   logic       grant0, grant1;
   job_t       sel_job;

   // Pointer only breaks ties; a lone requester always wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign sel_job = grant1 ? job_t'{req1_central, req1_radius, req1_mode}
                           : job_t'{req0_central, req0_radius, req0_mode};

   always_comb begin
      state_d     = state_q;
      job_d       = job_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      eng_en_d    = 1'b0;
      res_valid_d = res_valid_q;
      cand_d      = cand_q;
      err_d       = err_q;
      wd_d        = wd_q;
      unique case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               job_d = sel_job;
               id_d  = grant1;
               if (sel_job.mode == 2'd3) begin
                  state_d     = RESP;
                  res_valid_d = 1'b1;
                  cand_d      = 8'd0;
                  err_d       = 1'b1;
               end else begin
                  state_d  = ISSUE;
                  eng_en_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            wd_d    = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + 8'd1;
            if (eng_valid) begin
               state_d     = RESP;
               res_valid_d = 1'b1;
               cand_d      = eng_candidate;
               err_d       = 1'b0;
            end else if (wd_q == WD_LAST) begin
               state_d     = RESP;
               res_valid_d = 1'b1;
               cand_d      = 8'd0;
               err_d       = 1'b1;
            end
         end
         RESP: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
               ptr_d       = ~id_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         job_q       <= '0;
         ptr_q       <= 1'b0;
         id_q        <= 1'b0;
         eng_en_q    <= 1'b0;
         res_valid_q <= 1'b0;
         cand_q      <= 8'd0;
         err_q       <= 1'b0;
         wd_q        <= 8'd0;
      end else begin
         state_q     <= state_d;
         job_q       <= job_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         eng_en_q    <= eng_en_d;
         res_valid_q <= res_valid_d;
         cand_q      <= cand_d;
         err_q       <= err_d;
         wd_q        <= wd_d;
      end
   end

   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign eng_en        = eng_en_q;
   assign eng_central   = job_q.central;
   assign eng_radius    = job_q.radius;
   assign eng_mode      = job_q.mode;
   assign res_valid     = res_valid_q;
   assign res_id        = id_q;
   assign res_candidate = cand_q;
   assign res_err       = err_q;

endmodule
